// File: rtl/call_stack_pkg.sv
// Shared CPU core definitions: stack operation encoding and core sizing defaults.
package cpu_pkg;

  localparam int unsigned CPU_PC_W        = 8;
  localparam int unsigned CPU_STACK_DEPTH = 8;

  typedef enum logic [2:0] {
    SOP_NONE,
    SOP_PUSH,
    SOP_POP,
    SOP_REPLACE,
    SOP_OVF,
    SOP_UNF
  } stack_op_t;

endpackage

// File: rtl/call_stack_sp_next_logic.sv
// Combinational op decode and head/count next-state for the return-address stack.
module sp_next_logic
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = CPU_STACK_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter bit          WRAP  = 1'b0
) (
  input  logic [PTR_W-1:0] head,
  input  logic [PTR_W:0]   count,
  input  logic             push,
  input  logic             pop,
  output stack_op_t        op,
  output logic [PTR_W-1:0] head_nxt,
  output logic [PTR_W:0]   count_nxt
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic is_empty;
  logic is_full;

  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_CNT);

  always_comb begin
    op        = SOP_NONE;
    head_nxt  = head;
    count_nxt = count;
    // push&pop on an empty stack degrades to a plain push
    if (push && pop && !is_empty) begin
      op = SOP_REPLACE;
    end else if (push) begin
      if (is_full) begin
        op = SOP_OVF;
        if (WRAP) begin
          head_nxt = head + PTR_W'(1);
        end
      end else begin
        op        = SOP_PUSH;
        head_nxt  = head + PTR_W'(1);
        count_nxt = count + (PTR_W+1)'(1);
      end
    end else if (pop) begin
      if (is_empty) begin
        op = SOP_UNF;
      end else begin
        op        = SOP_POP;
        head_nxt  = head - PTR_W'(1);
        count_nxt = count - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack: registered storage, head pointer, count and sticky flags.
// Define CALL_STACK_WRAP_EN to let a push while full overwrite the oldest entry.
module call_stack
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_PC_W,
  parameter int unsigned DEPTH  = CPU_STACK_DEPTH,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic              err_clr,
  output logic [DATA_W-1:0] top,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

`ifdef CALL_STACK_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  stack_op_t         op;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_addr;
  logic [PTR_W-1:0]  top_idx;

  sp_next_logic #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WRAP  (WRAP_EN)
  ) u_sp_next (
    .head      (head_q),
    .count     (count_q),
    .push      (push),
    .pop       (pop),
    .op        (op),
    .head_nxt  (head_d),
    .count_nxt (count_d)
  );

  always_comb begin
    wr_en   = (op == SOP_PUSH) || (op == SOP_REPLACE) || ((op == SOP_OVF) && WRAP_EN);
    wr_addr = (op == SOP_REPLACE) ? (head_q - PTR_W'(1)) : head_q;
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    overflow_d  = err_clr ? 1'b0 : overflow_q;
    underflow_d = err_clr ? 1'b0 : underflow_q;
    if (op == SOP_OVF) overflow_d  = 1'b1;
    if (op == SOP_UNF) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= push_data;
    end
  end

  assign top_idx   = head_q - PTR_W'(1);
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign count     = count_q;
  assign top       = empty ? '0 : mem_q[top_idx];
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed self-checking bench for call_stack at DATA_W=8, DEPTH=4.
module tb_call_stack;

  logic       clk;
  logic       rst_n;
  logic       push;
  logic       pop;
  logic [7:0] push_data;
  logic       err_clr;
  logic [7:0] top;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  int unsigned n_cmp;
  int unsigned n_err;

  call_stack #(
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .err_clr   (err_clr),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the sampling edge.
  task automatic step(input logic p, input logic q, input logic [7:0] d, input logic c);
    push      = p;
    pop       = q;
    push_data = d;
    err_clr   = c;
    @(posedge clk);
    #1;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    err_clr   = 1'b0;
  endtask

  logic [7:0] ovf_top;
  logic [7:0] pop_seq [4];

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    err_clr   = 1'b0;
`ifdef CALL_STACK_WRAP_EN
    ovf_top    = 8'h55;
    pop_seq[0] = 8'h55; pop_seq[1] = 8'h44; pop_seq[2] = 8'h33; pop_seq[3] = 8'h22;
`else
    ovf_top    = 8'h44;
    pop_seq[0] = 8'h44; pop_seq[1] = 8'h33; pop_seq[2] = 8'h22; pop_seq[3] = 8'h11;
`endif

    // 1: reset and idle
    #12;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    rst_n = 1'b1;
    step(0, 0, 8'h00, 0);
    check_eq("idle_count", 32'(count), 32'd0);
    check_eq("idle_empty", 32'(empty), 32'd1);
    check_eq("idle_top", 32'(top), 32'h00);
    check_eq("idle_ovf", 32'(overflow), 32'd0);
    check_eq("idle_unf", 32'(underflow), 32'd0);

    // 2: fill then drain
    step(1, 0, 8'h11, 0);
    check_eq("push1_top", 32'(top), 32'h11);
    step(1, 0, 8'h22, 0);
    step(1, 0, 8'h33, 0);
    check_eq("push3_full", 32'(full), 32'd0);
    step(1, 0, 8'h44, 0);
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_count", 32'(count), 32'd4);
    check_eq("fill_top", 32'(top), 32'h44);
    step(0, 1, 8'h00, 0);
    check_eq("pop1_top", 32'(top), 32'h33);
    step(0, 1, 8'h00, 0);
    check_eq("pop2_top", 32'(top), 32'h22);
    step(0, 1, 8'h00, 0);
    check_eq("pop3_top", 32'(top), 32'h11);
    step(0, 1, 8'h00, 0);
    check_eq("pop4_top", 32'(top), 32'h00);
    check_eq("pop4_empty", 32'(empty), 32'd1);

    // 3: underflow and err_clr interplay
    step(0, 1, 8'h00, 0);
    check_eq("unf_count", 32'(count), 32'd0);
    check_eq("unf_flag", 32'(underflow), 32'd1);
    step(0, 0, 8'h00, 1);
    check_eq("unf_clr", 32'(underflow), 32'd0);
    step(0, 1, 8'h00, 1);
    check_eq("unf_clr_wins", 32'(underflow), 32'd1);
    step(0, 0, 8'h00, 1);
    check_eq("unf_clr2", 32'(underflow), 32'd0);
    step(1, 1, 8'h77, 0);
    check_eq("pp_empty_count", 32'(count), 32'd1);
    check_eq("pp_empty_top", 32'(top), 32'h77);
    check_eq("pp_empty_unf", 32'(underflow), 32'd0);
    step(0, 1, 8'h00, 0);
    check_eq("pp_empty_drain", 32'(empty), 32'd1);

    // 4: replace
    step(1, 0, 8'hA0, 0);
    step(1, 0, 8'hB0, 0);
    step(1, 1, 8'hC0, 0);
    check_eq("repl_count", 32'(count), 32'd2);
    check_eq("repl_top", 32'(top), 32'hC0);
    step(0, 1, 8'h00, 0);
    check_eq("repl_pop_top", 32'(top), 32'hA0);
    step(0, 1, 8'h00, 0);
    check_eq("repl_drain", 32'(empty), 32'd1);

    // 5: push while full
    step(1, 0, 8'h11, 0);
    step(1, 0, 8'h22, 0);
    step(1, 0, 8'h33, 0);
    step(1, 0, 8'h44, 0);
    step(1, 0, 8'h55, 0);
    check_eq("ovf_top", 32'(top), 32'(ovf_top));
    check_eq("ovf_count", 32'(count), 32'd4);
    check_eq("ovf_full", 32'(full), 32'd1);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    step(0, 0, 8'h00, 1);
    check_eq("ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("ovf_pop%0d", i), 32'(top), 32'(pop_seq[i]));
      step(0, 1, 8'h00, 0);
    end
    check_eq("ovf_drain", 32'(empty), 32'd1);
    check_eq("ovf_drain_top", 32'(top), 32'h00);

    // 6: asynchronous reset between edges
    step(1, 0, 8'h11, 0);
    step(1, 0, 8'h22, 0);
    check_eq("pre_arst_count", 32'(count), 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_count", 32'(count), 32'd0);
    check_eq("arst_top", 32'(top), 32'h00);
    check_eq("arst_empty", 32'(empty), 32'd1);
    #2;
    rst_n = 1'b1;
    step(0, 0, 8'h00, 0);
    check_eq("post_arst_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
